// File: rtl/ex_dispatch_if.sv
// Issue-to-dispatcher bus: issued instruction in, execution-unit start,
// writeback/scoreboard-clear and error out.
interface ex_dispatch_if;
    logic        iss_dsp_valid;
    logic [1:0]  iss_dsp_func_unit;
    logic [4:0]  iss_dsp_regdest;
    logic        iss_dsp_writereg;
    logic [31:0] iss_dsp_rega;
    logic [31:0] iss_dsp_regb;

    logic        dsp_iss_stall;
    logic [2:0]  dsp_fu_go;
    logic [31:0] dsp_fu_rega;
    logic [31:0] dsp_fu_regb;
    logic        dsp_wb_valid;
    logic [1:0]  dsp_wb_unit;
    logic [4:0]  dsp_wb_regdest;
    logic        dsp_sb_clear;
    logic        dsp_err;

    modport master (
        output iss_dsp_valid, iss_dsp_func_unit, iss_dsp_regdest,
               iss_dsp_writereg, iss_dsp_rega, iss_dsp_regb,
        input  dsp_iss_stall, dsp_fu_go, dsp_fu_rega, dsp_fu_regb,
               dsp_wb_valid, dsp_wb_unit, dsp_wb_regdest, dsp_sb_clear, dsp_err
    );

    modport slave (
        input  iss_dsp_valid, iss_dsp_func_unit, iss_dsp_regdest,
               iss_dsp_writereg, iss_dsp_rega, iss_dsp_regb,
        output dsp_iss_stall, dsp_fu_go, dsp_fu_rega, dsp_fu_regb,
               dsp_wb_valid, dsp_wb_unit, dsp_wb_regdest, dsp_sb_clear, dsp_err
    );
endinterface

// File: rtl/ex_dispatch.sv
// Functional-unit dispatcher: per-unit latency slots, fixed-priority completion
// arbitration (MUL > MEM > ALU). Define DISPATCH_MUL_PIPE_EN for a pipelined MUL.
module ex_dispatch #(
    parameter int ALU_LAT = 1,
    parameter int MEM_LAT = 3,
    parameter int MUL_LAT = 4
) (
    input  logic         clock,
    input  logic         reset,
    ex_dispatch_if.slave bus
);
    localparam int NUM_UNITS = 3;
    localparam int TW        = 8;

    typedef struct packed {
        logic [4:0] regdest;
        logic       writereg;
    } wb_tag_t;

    logic [NUM_UNITS-1:0] occ, done, grant, free, acc, tgt;
    wb_tag_t [NUM_UNITS-1:0] tag_q;
    wb_tag_t iss_tag, wb_tag;
    logic       tgt_busy;
    logic [1:0] wb_unit;
    logic [2:0]  go_q;
    logic [31:0] rega_q, regb_q;
    logic        err_q;

    assign iss_tag = {bus.iss_dsp_regdest, bus.iss_dsp_writereg};

`ifdef DISPATCH_MUL_PIPE_EN
    localparam int NUM_SLOTS = 2;

    // MUL is a fixed-depth shift pipe; top priority guarantees a grant on exit.
    logic    [MUL_LAT:1] vld_pipe;
    wb_tag_t [MUL_LAT:1] tag_pipe;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
        end else begin
            vld_pipe[1] <= acc[2];
            tag_pipe[1] <= iss_tag;
            for (int i = 2; i <= MUL_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign occ[2]   = 1'b0;
    assign done[2]  = vld_pipe[MUL_LAT];
    assign tag_q[2] = tag_pipe[MUL_LAT];
`else
    localparam int NUM_SLOTS = 3;
`endif

    // Blocking slots: load on accept, count down, sit DONE until granted.
    for (genvar u = 0; u < NUM_SLOTS; u++) begin : g_slot
        localparam int LAT = (u == 0) ? ALU_LAT : (u == 1) ? MEM_LAT : MUL_LAT;
        logic          occ_q;
        logic [TW-1:0] timer;
        wb_tag_t       tag;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                occ_q <= 1'b0;
                timer <= '0;
                tag   <= '0;
            end else if (acc[u]) begin
                occ_q <= 1'b1;
                timer <= TW'(LAT - 1);
                tag   <= iss_tag;
            end else if (grant[u]) begin
                occ_q <= 1'b0;
            end else if (occ_q && timer != '0) begin
                timer <= timer - TW'(1);
            end
        end

        assign occ[u]   = occ_q;
        assign done[u]  = occ_q && (timer == '0);
        assign tag_q[u] = tag;
    end

    assign grant[2] = done[2];
    assign grant[1] = done[1] & ~done[2];
    assign grant[0] = done[0] & ~done[1] & ~done[2];

    // A slot being granted this cycle can take the next op in the same cycle.
    assign free = ~occ | grant;

    always_comb begin
        tgt = '0;
        case (bus.iss_dsp_func_unit)
            2'b00:   tgt = 3'b001;
            2'b01:   tgt = 3'b010;
            2'b10:   tgt = 3'b100;
            default: tgt = 3'b000;
        endcase
        tgt_busy = |(tgt & ~free);
        acc      = (bus.iss_dsp_valid && !tgt_busy) ? tgt : 3'b000;
    end

    always_comb begin
        wb_tag  = tag_q[0];
        wb_unit = 2'd0;
        if (grant[2]) begin
            wb_tag  = tag_q[2];
            wb_unit = 2'd2;
        end else if (grant[1]) begin
            wb_tag  = tag_q[1];
            wb_unit = 2'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            go_q   <= '0;
            rega_q <= '0;
            regb_q <= '0;
            err_q  <= 1'b0;
        end else begin
            go_q  <= acc;
            err_q <= bus.iss_dsp_valid && (bus.iss_dsp_func_unit == 2'b11);
            if (|acc) begin
                rega_q <= bus.iss_dsp_rega;
                regb_q <= bus.iss_dsp_regb;
            end
        end
    end

    assign bus.dsp_iss_stall  = bus.iss_dsp_valid & tgt_busy;
    assign bus.dsp_fu_go      = go_q;
    assign bus.dsp_fu_rega    = rega_q;
    assign bus.dsp_fu_regb    = regb_q;
    assign bus.dsp_err        = err_q;
    assign bus.dsp_wb_valid   = |done;
    assign bus.dsp_wb_unit    = wb_unit;
    assign bus.dsp_wb_regdest = (|done) ? wb_tag.regdest : 5'd0;
    assign bus.dsp_sb_clear   = (|done) & wb_tag.writereg;
endmodule

// File: tb/tb_ex_dispatch.sv
// Randomized bench for ex_dispatch against an absolute-time occupancy model,
// plus directed scenarios with literal expectations.
module tb_ex_dispatch;
    localparam int ALU_LAT = 1;
    localparam int MEM_LAT = 3;
    localparam int MUL_LAT = 4;

    logic clock = 1'b0;
    logic reset;
    ex_dispatch_if bus();

    ex_dispatch #(.ALU_LAT(ALU_LAT), .MEM_LAT(MEM_LAT), .MUL_LAT(MUL_LAT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         exit_t;
        logic [4:0] rd;
        bit         wr;
    } pend_t;

    int          n_chk = 0;
    int          n_fail = 0;
    int          t = 0;
    bit          m_occ [3];
    int          m_ready [3];
    logic [4:0]  m_rd [3];
    bit          m_wr [3];
    pend_t       mulq [$];
    logic [2:0]  e_go;
    logic [31:0] e_a, e_b;
    bit          e_err;

    function automatic int lat_of(input int u);
        return (u == 0) ? ALU_LAT : (u == 1) ? MEM_LAT : MUL_LAT;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, t);
        end
    endtask

    // Model: each unit holds an op until its ready time, then waits for a grant.
    task automatic model_step(input bit r, input bit v, input logic [1:0] fu,
                              input logic [4:0] rd, input bit wr,
                              input logic [31:0] a, input logic [31:0] b);
        bit done [3];
        int g;
        bit busy, take;
        if (r) begin
            for (int u = 0; u < 3; u++) m_occ[u] = 0;
            mulq.delete();
            e_go = 3'b000;
            e_err = 0;
        end
        for (int u = 0; u < 3; u++) done[u] = m_occ[u] && (t >= m_ready[u]);
`ifdef DISPATCH_MUL_PIPE_EN
        done[2] = (mulq.size() > 0) && (mulq[0].exit_t == t);
`endif
        g = done[2] ? 2 : done[1] ? 1 : done[0] ? 0 : -1;
        busy = (fu != 2'b11) && m_occ[fu] && (g != int'(fu));
`ifdef DISPATCH_MUL_PIPE_EN
        if (fu == 2'b10) busy = 0;
`endif
        chk("stall", bus.dsp_iss_stall, v && busy);
        chk("wb_valid", bus.dsp_wb_valid, g >= 0);
        if (g >= 0) begin
`ifdef DISPATCH_MUL_PIPE_EN
            if (g == 2) begin
                chk("wb_regdest", bus.dsp_wb_regdest, mulq[0].rd);
                chk("sb_clear", bus.dsp_sb_clear, mulq[0].wr);
            end else begin
                chk("wb_regdest", bus.dsp_wb_regdest, m_rd[g]);
                chk("sb_clear", bus.dsp_sb_clear, m_wr[g]);
            end
`else
            chk("wb_regdest", bus.dsp_wb_regdest, m_rd[g]);
            chk("sb_clear", bus.dsp_sb_clear, m_wr[g]);
`endif
            chk("wb_unit", bus.dsp_wb_unit, g);
        end else begin
            chk("sb_clear", bus.dsp_sb_clear, 0);
        end
        chk("fu_go", bus.dsp_fu_go, e_go);
        if (e_go != 3'b000) begin
            chk("fu_rega", bus.dsp_fu_rega, e_a);
            chk("fu_regb", bus.dsp_fu_regb, e_b);
        end
        chk("err", bus.dsp_err, e_err);

        if (!r) begin
            if (g >= 0) begin
`ifdef DISPATCH_MUL_PIPE_EN
                if (g == 2) void'(mulq.pop_front());
                else m_occ[g] = 0;
`else
                m_occ[g] = 0;
`endif
            end
            take = v && (fu != 2'b11) && !busy;
            e_go = 3'b000;
            if (take) begin
                e_go = 3'b001 << fu;
                e_a = a;
                e_b = b;
`ifdef DISPATCH_MUL_PIPE_EN
                if (fu == 2'b10) mulq.push_back('{t + MUL_LAT, rd, wr});
                else begin
                    m_occ[fu] = 1; m_ready[fu] = t + lat_of(fu); m_rd[fu] = rd; m_wr[fu] = wr;
                end
`else
                m_occ[fu] = 1; m_ready[fu] = t + lat_of(fu); m_rd[fu] = rd; m_wr[fu] = wr;
`endif
            end
            e_err = v && (fu == 2'b11);
        end
        t++;
    endtask

    task automatic cycle(input bit r, input bit v, input logic [1:0] fu,
                         input logic [4:0] rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] b);
        @(posedge clock);
        #1;
        reset = r;
        bus.iss_dsp_valid     = v;
        bus.iss_dsp_func_unit = fu;
        bus.iss_dsp_regdest   = rd;
        bus.iss_dsp_writereg  = wr;
        bus.iss_dsp_rega      = a;
        bus.iss_dsp_regb      = b;
        @(negedge clock);
        model_step(r, v, fu, rd, wr, a, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 2'd0, 5'd0, 0, 32'd0, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        bus.iss_dsp_valid = 0; bus.iss_dsp_func_unit = 0; bus.iss_dsp_regdest = 0;
        bus.iss_dsp_writereg = 0; bus.iss_dsp_rega = 0; bus.iss_dsp_regb = 0;
        e_go = 0; e_a = 0; e_b = 0; e_err = 0;
        for (int u = 0; u < 3; u++) begin m_occ[u] = 0; m_ready[u] = 0; m_rd[u] = 0; m_wr[u] = 0; end

        // Reset state, with an ALU op presented while reset is high
        cycle(1, 0, 2'd0, 5'd0, 0, 32'd0, 32'd0);
        cycle(1, 1, 2'd0, 5'd5, 1, 32'h1, 32'h2);
        chk("rst_stall", bus.dsp_iss_stall, 0);
        chk("rst_go", bus.dsp_fu_go, 0);
        chk("rst_rega", bus.dsp_fu_rega, 0);
        chk("rst_regb", bus.dsp_fu_regb, 0);
        chk("rst_wb_regdest", bus.dsp_wb_regdest, 0);
        chk("rst_wb_unit", bus.dsp_wb_unit, 0);
        idle(2);
        chk("rst_no_wb", bus.dsp_wb_valid, 0);

        // Single ALU op
        cycle(0, 1, 2'd0, 5'd5, 1, 32'hA, 32'hB);
        cycle(0, 0, 2'd0, 5'd0, 0, 32'd0, 32'd0);
        chk("alu_go", bus.dsp_fu_go, 3'b001);
        chk("alu_rega", bus.dsp_fu_rega, 32'hA);
        chk("alu_wb", bus.dsp_wb_valid, 1);
        chk("alu_sb", bus.dsp_sb_clear, 1);
        chk("alu_rd", bus.dsp_wb_regdest, 5);
        idle(3);

        // Back-to-back MEM: second held until the first is granted
        cycle(0, 1, 2'd1, 5'd7, 1, 32'h7, 32'h7);
        cycle(0, 1, 2'd1, 5'd8, 0, 32'h8, 32'h8);
        chk("mem_stall_t1", bus.dsp_iss_stall, 1);
        cycle(0, 1, 2'd1, 5'd8, 0, 32'h8, 32'h8);
        chk("mem_stall_t2", bus.dsp_iss_stall, 1);
        cycle(0, 1, 2'd1, 5'd8, 0, 32'h8, 32'h8);
        chk("mem_stall_t3", bus.dsp_iss_stall, 0);
        chk("mem_wb_t3", bus.dsp_wb_regdest, 7);
        idle(2);
        cycle(0, 0, 2'd0, 5'd0, 0, 32'd0, 32'd0);
        chk("mem_wb_t6", bus.dsp_wb_valid, 1);
        chk("mem_rd_t6", bus.dsp_wb_regdest, 8);
        chk("mem_sb_t6", bus.dsp_sb_clear, 0);
        idle(3);

        // MUL and MEM finish together; MUL wins, MEM retries
        cycle(0, 1, 2'd2, 5'd9, 1, 32'h9, 32'h9);
        cycle(0, 1, 2'd1, 5'd10, 1, 32'h10, 32'h10);
        idle(2);
        chk("arb_t3_none", bus.dsp_wb_valid, 0);
        cycle(0, 1, 2'd0, 5'd11, 1, 32'h11, 32'h11);
        chk("arb_t4_stall", bus.dsp_iss_stall, 0);
        chk("arb_t4_unit", bus.dsp_wb_unit, 2);
        chk("arb_t4_rd", bus.dsp_wb_regdest, 9);
        cycle(0, 0, 2'd0, 5'd0, 0, 32'd0, 32'd0);
        chk("arb_t5_unit", bus.dsp_wb_unit, 1);
        chk("arb_t5_rd", bus.dsp_wb_regdest, 10);
        cycle(0, 0, 2'd0, 5'd0, 0, 32'd0, 32'd0);
        chk("arb_t6_rd", bus.dsp_wb_regdest, 11);
        idle(3);

        // Consecutive MULs
        cycle(0, 1, 2'd2, 5'd1, 1, 32'h1, 32'h1);
`ifdef DISPATCH_MUL_PIPE_EN
        cycle(0, 1, 2'd2, 5'd2, 1, 32'h2, 32'h2);
        chk("mulp_stall_t1", bus.dsp_iss_stall, 0);
        cycle(0, 1, 2'd2, 5'd3, 1, 32'h3, 32'h3);
        chk("mulp_stall_t2", bus.dsp_iss_stall, 0);
        idle(1);
        for (int i = 1; i <= 3; i++) begin
            cycle(0, 0, 2'd0, 5'd0, 0, 32'd0, 32'd0);
            chk("mulp_wb_rd", bus.dsp_wb_regdest, i);
        end
`else
        cycle(0, 1, 2'd2, 5'd2, 1, 32'h2, 32'h2);
        chk("mul_stall_t1", bus.dsp_iss_stall, 1);
        cycle(0, 1, 2'd2, 5'd2, 1, 32'h2, 32'h2);
        cycle(0, 1, 2'd2, 5'd2, 1, 32'h2, 32'h2);
        cycle(0, 1, 2'd2, 5'd2, 1, 32'h2, 32'h2);
        chk("mul_stall_t4", bus.dsp_iss_stall, 0);
        chk("mul_wb_t4", bus.dsp_wb_regdest, 1);
`endif
        idle(8);

        // Invalid unit code
        cycle(0, 1, 2'd3, 5'd4, 1, 32'h4, 32'h4);
        chk("inv_stall", bus.dsp_iss_stall, 0);
        cycle(0, 0, 2'd0, 5'd0, 0, 32'd0, 32'd0);
        chk("inv_err", bus.dsp_err, 1);
        chk("inv_go", bus.dsp_fu_go, 0);
        chk("inv_wb", bus.dsp_wb_valid, 0);
        cycle(0, 0, 2'd0, 5'd0, 0, 32'd0, 32'd0);
        chk("inv_err_pulse", bus.dsp_err, 0);

        // Reset while a MUL is in flight
        cycle(0, 1, 2'd2, 5'd12, 1, 32'hC, 32'hC);
        idle(1);
        cycle(1, 0, 2'd0, 5'd0, 0, 32'd0, 32'd0);
        chk("midrst_wb", bus.dsp_wb_valid, 0);
        chk("midrst_sb", bus.dsp_sb_clear, 0);
        for (int i = 0; i < MUL_LAT + 2; i++) begin
            cycle(0, 0, 2'd0, 5'd0, 0, 32'd0, 32'd0);
            chk("midrst_no_wb", bus.dsp_wb_valid, 0);
        end

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                  2'($urandom_range(0, 3)), 5'($urandom), 1'($urandom),
                  $urandom, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
